// File: rtl/g15_key_conditioner.sv
// Multi-channel key/switch conditioner: synchronise, debounce, rise detect, and queue the first press.
// Optional hold-time stretching of key_level is compiled in with G15_KEY_STRETCH_EN.
module g15_key_conditioner #(
  parameter int N_CH    = 16,
  parameter int DEB_MS  = 4,
  parameter int HOLD_MS = 40
) (
  input  logic                    CLOCK,
  input  logic                    rst_n,
  input  logic                    tick_ms,
  input  logic [N_CH-1:0]         key_raw,
  output logic [N_CH-1:0]         key_level,
  output logic [N_CH-1:0]         key_rise,
  output logic                    key_valid,
  output logic [$clog2(N_CH)-1:0] key_code,
  input  logic                    key_ack,
  output logic                    key_overrun,
  input  logic                    clr_overrun
);

  localparam int CW = $clog2(N_CH);
  localparam int DW = (DEB_MS > 0) ? $clog2(DEB_MS + 1) : 1;

  if (N_CH < 2 || N_CH > 32 || DEB_MS < 0 || DEB_MS > 15 || HOLD_MS < 1 || HOLD_MS > 255) begin : g_bad_params
    $error("g15_key_conditioner: parameter out of range");
  end

  logic [N_CH-1:0] meta_reg;
  logic [N_CH-1:0] sync_reg;
  logic [N_CH-1:0] deb_reg;
  logic [N_CH-1:0] deb_next;
  logic [N_CH-1:0] rise_reg;
  logic [N_CH-1:0] rise_next;
  logic            valid_reg, valid_next;
  logic [CW-1:0]   code_reg, code_next;
  logic            ovr_reg, ovr_next;
  logic [CW-1:0]   first_code;
  logic            any_rise;
  logic            multi_rise;

  genvar gi;
  for (gi = 0; gi < N_CH; gi++) begin : g_ch
    if (DEB_MS == 0) begin : g_nodeb
      assign deb_next[gi] = sync_reg[gi];
    end else begin : g_deb
      logic [DW-1:0] cnt_reg, cnt_next;
      logic          deb_bit_next;

      // Any agreement between sync and deb restarts the count from zero.
      always_comb begin
        cnt_next     = cnt_reg;
        deb_bit_next = deb_reg[gi];
        if (sync_reg[gi] == deb_reg[gi]) begin
          cnt_next = '0;
        end else if (tick_ms) begin
          if (cnt_reg == DW'(DEB_MS - 1)) begin
            cnt_next     = '0;
            deb_bit_next = sync_reg[gi];
          end else begin
            cnt_next = cnt_reg + DW'(1);
          end
        end
      end

      always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
      end

      assign deb_next[gi] = deb_bit_next;
    end

    assign rise_next[gi] = deb_next[gi] & ~deb_reg[gi];

`ifdef G15_KEY_STRETCH_EN
    logic [7:0] hold_reg, hold_next;

    // Loaded on the same edge deb rises, so the stretch covers the press seamlessly.
    always_comb begin
      hold_next = hold_reg;
      if (rise_next[gi])
        hold_next = 8'(HOLD_MS);
      else if (tick_ms && hold_reg != 8'd0)
        hold_next = hold_reg - 8'd1;
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
      if (!rst_n) hold_reg <= 8'd0;
      else        hold_reg <= hold_next;
    end

    assign key_level[gi] = deb_reg[gi] | (hold_reg != 8'd0);
`else
    assign key_level[gi] = deb_reg[gi];
`endif
  end

  // Lowest-index rising channel wins the capture.
  always_comb begin
    first_code = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rise_reg[i]) first_code = CW'(i);
    end
  end

  assign any_rise   = |rise_reg;
  assign multi_rise = |(rise_reg & (rise_reg - N_CH'(1)));

  always_comb begin
    valid_next = valid_reg;
    code_next  = code_reg;
    ovr_next   = ovr_reg;
    if (clr_overrun) ovr_next = 1'b0;
    if (any_rise) begin
      if (!valid_reg || key_ack) begin
        valid_next = 1'b1;
        code_next  = first_code;
        if (multi_rise) ovr_next = 1'b1;
      end else begin
        ovr_next = 1'b1;
      end
    end else if (key_ack && valid_reg) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg  <= '0;
      sync_reg  <= '0;
      deb_reg   <= '0;
      rise_reg  <= '0;
      valid_reg <= 1'b0;
      code_reg  <= '0;
      ovr_reg   <= 1'b0;
    end else begin
      meta_reg  <= key_raw;
      sync_reg  <= meta_reg;
      deb_reg   <= deb_next;
      rise_reg  <= rise_next;
      valid_reg <= valid_next;
      code_reg  <= code_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign key_rise    = rise_reg;
  assign key_valid   = valid_reg;
  assign key_code    = code_reg;
  assign key_overrun = ovr_reg;

endmodule

// File: tb/tb_g15_key_conditioner.sv
// Directed bench for g15_key_conditioner: default instance (DEB_MS=4) plus a DEB_MS=0 instance.
module tb_g15_key_conditioner;

  logic        CLOCK = 1'b0;
  logic        rst_n;
  logic        tick_ms;
  logic [15:0] key_raw;
  logic [15:0] key_level;
  logic [15:0] key_rise;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack;
  logic        key_overrun;
  logic        clr_overrun;

  logic [3:0]  raw0;
  logic [3:0]  level0;
  logic [3:0]  rise0;
  logic        valid0;
  logic [1:0]  code0;
  logic        ack0;
  logic        ovr0;
  logic        clr0;

  int total = 0;
  int bad = 0;
  int rise2_cnt = 0;

  always #5 CLOCK = ~CLOCK;

  g15_key_conditioner dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .tick_ms(tick_ms), .key_raw(key_raw),
    .key_level(key_level), .key_rise(key_rise), .key_valid(key_valid),
    .key_code(key_code), .key_ack(key_ack), .key_overrun(key_overrun),
    .clr_overrun(clr_overrun)
  );

  g15_key_conditioner #(.N_CH(4), .DEB_MS(0)) dut0 (
    .CLOCK(CLOCK), .rst_n(rst_n), .tick_ms(tick_ms), .key_raw(raw0),
    .key_level(level0), .key_rise(rise0), .key_valid(valid0),
    .key_code(code0), .key_ack(ack0), .key_overrun(ovr0),
    .clr_overrun(clr0)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
      if (key_rise[2]) rise2_cnt++;
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_ms = 1'b1;
      cyc(1);
      tick_ms = 1'b0;
    end
  endtask

  task automatic do_reset;
    tick_ms = 0; key_raw = '0; key_ack = 0; clr_overrun = 0;
    raw0 = '0; ack0 = 0; clr0 = 0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset;
    tick_ms = 0; key_raw = 16'hFFFF; key_ack = 0; clr_overrun = 0;
    raw0 = 4'hF; ack0 = 0; clr0 = 0;
    rst_n = 1'b0;
    cyc(4);
    total++; if ({key_level, key_rise, key_valid, key_code, key_overrun} !== 37'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {key_level, key_rise, key_valid, key_code, key_overrun}); end
    total++; if ({level0, rise0, valid0, code0, ovr0} !== 12'd0) begin bad++; $display("FAIL reset_outputs_deb0: got %h want 0", {level0, rise0, valid0, code0, ovr0}); end
    do_reset;
  endtask

  task automatic test_basic_press;
    do_reset;
    key_raw[5] = 1'b1;
    cyc(3);
    tick_n(3);
    total++; if (key_level !== 16'h0000) begin bad++; $display("FAIL basic_early: level=%h want 0000", key_level); end
    tick_n(1);
    total++; if (key_level !== 16'h0020) begin bad++; $display("FAIL basic_level: level=%h want 0020", key_level); end
    total++; if (key_rise !== 16'h0020) begin bad++; $display("FAIL basic_rise: rise=%h want 0020", key_rise); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_latency: valid=%b want 0", key_valid); end
    cyc(1);
    total++; if (key_rise !== 16'h0000) begin bad++; $display("FAIL basic_rise_pulse: rise=%h want 0000", key_rise); end
    total++; if ({key_valid, key_code} !== {1'b1, 4'd5}) begin bad++; $display("FAIL basic_capture: valid=%b code=%0d want 1/5", key_valid, key_code); end
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL basic_ack: valid=%b want 0", key_valid); end
  endtask

  task automatic test_bounce;
    do_reset;
    rise2_cnt = 0;
    key_raw[2] = 1'b1;
    cyc(3);
    tick_n(3);
    key_raw[2] = 1'b0;
    cyc(3);
    tick_n(1);
    key_raw[2] = 1'b1;
    cyc(3);
    tick_n(3);
    total++; if (key_level[2] !== 1'b0) begin bad++; $display("FAIL bounce_early: level2=%b want 0", key_level[2]); end
    tick_n(1);
    total++; if (key_rise !== 16'h0004) begin bad++; $display("FAIL bounce_rise: rise=%h want 0004", key_rise); end
    cyc(5);
    total++; if (rise2_cnt !== 1) begin bad++; $display("FAIL bounce_count: rises=%0d want 1", rise2_cnt); end
  endtask

  task automatic test_simultaneous;
    do_reset;
    key_raw = 16'h0088;
    cyc(3);
    tick_n(4);
    total++; if (key_rise !== 16'h0088) begin bad++; $display("FAIL simul_rise: rise=%h want 0088", key_rise); end
    cyc(1);
    total++; if ({key_valid, key_code, key_overrun} !== {1'b1, 4'd3, 1'b1}) begin bad++; $display("FAIL simul_capture: valid=%b code=%0d ovr=%b want 1/3/1", key_valid, key_code, key_overrun); end
  endtask

  task automatic test_ack_with_rise;
    do_reset;
    key_raw = 16'h0008;
    cyc(3);
    tick_n(4);
    cyc(1);
    total++; if ({key_valid, key_code, key_overrun} !== {1'b1, 4'd3, 1'b0}) begin bad++; $display("FAIL ackrise_pending: valid=%b code=%0d ovr=%b want 1/3/0", key_valid, key_code, key_overrun); end
    key_raw = 16'h0208;
    cyc(3);
    tick_n(4);
    total++; if (key_rise !== 16'h0200) begin bad++; $display("FAIL ackrise_rise9: rise=%h want 0200", key_rise); end
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
    total++; if ({key_valid, key_code, key_overrun} !== {1'b1, 4'd9, 1'b0}) begin bad++; $display("FAIL ackrise_swap: valid=%b code=%0d ovr=%b want 1/9/0", key_valid, key_code, key_overrun); end
  endtask

  task automatic test_full_hold;
    do_reset;
    key_raw = 16'h0008;
    cyc(3);
    tick_n(4);
    cyc(1);
    key_raw = 16'h0208;
    cyc(3);
    tick_n(4);
    cyc(1);
    total++; if ({key_valid, key_code, key_overrun} !== {1'b1, 4'd3, 1'b1}) begin bad++; $display("FAIL full_overrun: valid=%b code=%0d ovr=%b want 1/3/1", key_valid, key_code, key_overrun); end
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    total++; if (key_overrun !== 1'b0) begin bad++; $display("FAIL full_clear: ovr=%b want 0", key_overrun); end
    key_raw = 16'h0A08;
    cyc(3);
    tick_n(4);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    total++; if ({key_overrun, key_code} !== {1'b1, 4'd3}) begin bad++; $display("FAIL full_set_wins: ovr=%b code=%0d want 1/3", key_overrun, key_code); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    key_raw = 16'h0040;
    cyc(3);
    tick_n(2);
    rst_n = 1'b0;
    cyc(1);
    total++; if ({key_level, key_rise, key_valid, key_code, key_overrun} !== 37'd0) begin bad++; $display("FAIL midreset_outputs: got %h want 0", {key_level, key_rise, key_valid, key_code, key_overrun}); end
    rst_n = 1'b1;
    cyc(3);
    tick_n(3);
    total++; if (key_level !== 16'h0000) begin bad++; $display("FAIL midreset_early: level=%h want 0000", key_level); end
    tick_n(1);
    total++; if (key_level !== 16'h0040) begin bad++; $display("FAIL midreset_level: level=%h want 0040", key_level); end
  endtask

  task automatic test_release;
    do_reset;
    key_raw = 16'h0010;
    cyc(3);
    tick_n(4);
    total++; if (key_level !== 16'h0010) begin bad++; $display("FAIL release_press: level=%h want 0010", key_level); end
    tick_n(10);
    key_raw = 16'h0000;
    cyc(3);
`ifdef G15_KEY_STRETCH_EN
    tick_n(29);
    total++; if (key_level !== 16'h0010) begin bad++; $display("FAIL stretch_hold: level=%h want 0010", key_level); end
    tick_n(1);
    total++; if (key_level !== 16'h0000) begin bad++; $display("FAIL stretch_end: level=%h want 0000", key_level); end
`else
    tick_n(3);
    total++; if (key_level !== 16'h0010) begin bad++; $display("FAIL release_hold: level=%h want 0010", key_level); end
    tick_n(1);
    total++; if (key_level !== 16'h0000) begin bad++; $display("FAIL release_fall: level=%h want 0000", key_level); end
`endif
  endtask

  task automatic test_no_debounce;
    do_reset;
    raw0 = 4'b0010;
    cyc(2);
    total++; if (rise0 !== 4'b0000) begin bad++; $display("FAIL deb0_early: rise=%b want 0000", rise0); end
    cyc(1);
    total++; if ({rise0, level0} !== {4'b0010, 4'b0010}) begin bad++; $display("FAIL deb0_rise: rise=%b level=%b want 0010/0010", rise0, level0); end
    cyc(1);
    total++; if ({valid0, code0, rise0} !== {1'b1, 2'd1, 4'b0000}) begin bad++; $display("FAIL deb0_capture: valid=%b code=%0d rise=%b want 1/1/0000", valid0, code0, rise0); end
  endtask

  initial begin
    test_reset;
    test_basic_press;
    test_bounce;
    test_simultaneous;
    test_ack_with_rise;
    test_full_hold;
    test_reset_mid;
    test_release;
    test_no_debounce;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
